pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Program-counter register and next-PC sequencer for the 32-bit MIPS fetch stage. Consumes
//  the word-aligned branch offset from the shift-left-2 stage, forms branch and jump targets,
//  and redirects fetch with a timed flush of wrong-path instructions in IF/ID.
//  Also keeps a saturating redirect counter for debug and performance.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  FLUSH_CYCLES  1              cycles FLUSH_OUT stays high per redirect (1..15)
//  CNT_W         16             width of REDIRECT_CNT
// PORTS
//  CLK           in   1      rising-edge clock
//  RST_N         in   1      asynchronous active-low reset
//  STALL         in   1      hold PC (hazard unit)
//  BR_PC4        in   32     PC+4 of the resolving branch/jump instruction
//  BRANCH_OFFSET in   32     sign-extended offset, already shifted left 2
//  BRANCH_TAKEN  in   1      branch condition true this cycle
//  JUMP          in   1      J/JAL resolving this cycle
//  JUMP_INDEX    in   26     instr[25:0] of the jump
//  PC            out  32     current fetch address
//  PC_PLUS4      out  32     PC + 4, combinational
//  FLUSH_OUT     out  1      squash younger instructions in IF/ID
//  ADDR_ERR      out  1      sticky: redirect target had nonzero bits[1:0]
//  REDIRECT_CNT  out  CNT_W  number of redirects taken, saturating
// BEHAVIOUR
//  Reset (RST_N low, asynchronous): PC=RESET_VECTOR, FLUSH_OUT=0, ADDR_ERR=0,
//   REDIRECT_CNT=0, state=RUN, flush counter=0. Reset wins over every other input.
//  Arithmetic: every add is mod 2^32; carry out is discarded. PC_PLUS4 = PC + 32'd4.
//   BR_TGT = BR_PC4 + BRANCH_OFFSET. J_TGT = {BR_PC4[31:28], JUMP_INDEX, 2'b00}.
//  Redirect: REDIR = JUMP | BRANCH_TAKEN. JUMP has priority over BRANCH_TAKEN.
//   TGT = JUMP ? J_TGT : BR_TGT.
//  PC update at each rising edge (priority order):
//   1. REDIR: PC <= {TGT[31:2], 2'b00}. This happens even when STALL is high.
//   2. else STALL: PC holds.
//   3. else: PC <= PC_PLUS4.
//  Redirect latency: the target appears on PC in the cycle after REDIR is sampled.
//  ADDR_ERR: set on an edge where REDIR is high and TGT[1:0] != 0. It is cleared only by reset.
//  FSM:
//   RUN -> FLUSH on REDIR; the flush counter loads FLUSH_CYCLES-1.
//   In FLUSH: FLUSH_OUT=1 (registered; high from the cycle after REDIR).
//    - REDIR again: new target is taken, and the counter reloads FLUSH_CYCLES-1.
//    - Otherwise, if the counter is 0: go to RUN.
//    - Otherwise: decrement the counter. STALL does not pause the count.
//   In RUN: FLUSH_OUT=0.
//  REDIRECT_CNT: +1 on every edge where REDIR is high; it sticks at all-ones.
//  The PC advances normally during FLUSH; fetches from the target are valid.
//  Unknown FSM state encodings recover to RUN.
// TESTING
//  1. Reset release, no redirect, STALL=0 -> PC sequence 0,4,8,C; FLUSH_OUT=0, REDIRECT_CNT=0.
//  2. BR_PC4=0x100, BRANCH_OFFSET=0xFFFF_FFF0, BRANCH_TAKEN=1 for 1 cycle
//     -> next PC=0xF0; FLUSH_OUT=1 for exactly 1 cycle; REDIRECT_CNT=1.
//  3. JUMP=1 and BRANCH_TAKEN=1 together, BR_PC4=0x4000_0010, JUMP_INDEX=0x0000040,
//     STALL=1 -> PC=0x4000_0100 (jump wins, stall overridden).
//  4. FLUSH_CYCLES=3; a second branch 1 cycle into the flush -> second target is loaded;
//     FLUSH_OUT is high for 4 consecutive cycles in total.
//  5. BR_PC4=0xFFFF_FFFC, offset=0x8 -> PC=0x4 (wrap). BR_PC4=0x102, offset 0 -> PC=0x100,
//     ADDR_ERR=1, and ADDR_ERR stays 1 after later legal redirects.
//  6. CNT_W=2, 5 redirects -> REDIRECT_CNT=3. Assert RST_N low mid-FLUSH, asynchronously
//     -> PC=RESET_VECTOR and FLUSH_OUT=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Fetch-stage bundle between the PC sequencer and its neighbours: the redirect request from
// the branch resolver in, and the fetch address, flush and status out.
interface pc_redirect_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic [31:0]      br_pc4;
  logic [31:0]      branch_offset;
  logic             branch_taken;
  logic             jump;
  logic [25:0]      jump_index;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             flush_out;
  logic             addr_err;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall, br_pc4, branch_offset, branch_taken, jump, jump_index,
    input  pc, pc_plus4, flush_out, addr_err, redirect_cnt
  );

  modport slave (
    input  stall, br_pc4, branch_offset, branch_taken, jump, jump_index,
    output pc, pc_plus4, flush_out, addr_err, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// PC register and next-PC sequencer for the MIPS fetch stage: branch/jump redirect, timed
// IF/ID flush, sticky misaligned-target flag and a saturating redirect counter.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  pc_redirect_unit_if.slave bus
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun   = 2'b01,
    StFlush = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt;
  logic        redir;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = bus.br_pc4 + bus.branch_offset;
  assign j_tgt    = {bus.br_pc4[31:28], bus.jump_index, 2'b00};
  assign redir    = bus.jump | bus.branch_taken;
  assign tgt      = bus.jump ? j_tgt : br_tgt;

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (redir) begin
      // A redirect overrides a hazard stall: the wrong-path fetch must not be held.
      pc_d = {tgt[31:2], 2'b00};
      if (tgt[1:0] != 2'b00) err_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (!bus.stall) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      StRun: begin
        if (redir) begin
          state_d = StFlush;
          fcnt_d  = FlushLoad;
        end
      end
      StFlush: begin
        if (redir) begin
          fcnt_d = FlushLoad;
        end else if (fcnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      fcnt_q  <= 4'd0;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.flush_out    = (state_q == StFlush);
  assign bus.addr_err     = err_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a vector table on a default instance, plus hand
// sequences for overlapping flushes, counter saturation and async reset on a second instance.
module tb_pc_redirect_unit;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   checks;
  int   failures;

  pc_redirect_unit_if #(.CNT_W(16)) bus_a ();
  pc_redirect_unit_if #(.CNT_W(2))  bus_b ();

  pc_redirect_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .FLUSH_CYCLES(1),
    .CNT_W       (16)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_a_n),
    .bus  (bus_a)
  );

  pc_redirect_unit #(
    .RESET_VECTOR(32'h0000_1000),
    .FLUSH_CYCLES(3),
    .CNT_W       (2)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_b_n),
    .bus  (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic [31:0] br_pc4;
    logic [31:0] off;
    logic        bt;
    logic        jump;
    logic [25:0] jidx;
    logic [31:0] pc;
    logic        flush;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic stall, logic [31:0] br_pc4, logic [31:0] off, logic bt,
                              logic jump, logic [25:0] jidx, logic [31:0] pc, logic flush,
                              logic err, logic [15:0] cnt);
    vec_t v;
    v.stall = stall; v.br_pc4 = br_pc4; v.off = off; v.bt = bt; v.jump = jump;
    v.jidx = jidx; v.pc = pc; v.flush = flush; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_b(logic stall, logic bt, logic [31:0] br_pc4, logic [31:0] off);
    bus_b.stall         = stall;
    bus_b.branch_taken  = bt;
    bus_b.br_pc4        = br_pc4;
    bus_b.branch_offset = off;
    bus_b.jump          = 1'b0;
    bus_b.jump_index    = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int flush_hi;

  initial begin
    checks   = 0;
    failures = 0;
    flush_hi = 0;

    //            stall br_pc4        off           bt jmp jidx        pc            f  e  cnt
    vecs[0]  = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_0004, 0, 0, 16'd0);
    vecs[1]  = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_0008, 0, 0, 16'd0);
    vecs[2]  = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_000C, 0, 0, 16'd0);
    vecs[3]  = mk(0, 32'h100,      32'hFFFF_FFF0, 1, 0, 26'h0,  32'h0000_00F0, 1, 0, 16'd1);
    vecs[4]  = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_00F4, 0, 0, 16'd1);
    vecs[5]  = mk(1, 32'h4000_0010, 32'h0,       1, 1, 26'h40, 32'h4000_0100, 1, 0, 16'd2);
    vecs[6]  = mk(1, 32'h0,        32'h0,        0, 0, 26'h0,  32'h4000_0100, 0, 0, 16'd2);
    vecs[7]  = mk(0, 32'hFFFF_FFFC, 32'h8,       1, 0, 26'h0,  32'h0000_0004, 1, 0, 16'd3);
    vecs[8]  = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_0008, 0, 0, 16'd3);
    vecs[9]  = mk(0, 32'h102,      32'h0,        1, 0, 26'h0,  32'h0000_0100, 1, 1, 16'd4);
    vecs[10] = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_0104, 0, 1, 16'd4);
    vecs[11] = mk(0, 32'h0,        32'h0,        0, 1, 26'h10, 32'h0000_0040, 1, 1, 16'd5);
    vecs[12] = mk(0, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_0044, 0, 1, 16'd5);
    vecs[13] = mk(1, 32'h0,        32'h0,        0, 0, 26'h0,  32'h0000_0044, 0, 1, 16'd5);

    bus_a.stall = 0; bus_a.br_pc4 = 0; bus_a.branch_offset = 0;
    bus_a.branch_taken = 0; bus_a.jump = 0; bus_a.jump_index = 0;
    drive_b(0, 0, 32'h0, 32'h0);
    rst_a_n = 0;
    rst_b_n = 0;
    #12;
    rst_a_n = 1;
    rst_b_n = 1;
    #1;

    chk("a_reset_pc",    bus_a.pc, 32'h0);
    chk("a_reset_pc4",   bus_a.pc_plus4, 32'h4);
    chk("a_reset_flush", 32'(bus_a.flush_out), 32'h0);
    chk("a_reset_err",   32'(bus_a.addr_err), 32'h0);
    chk("a_reset_cnt",   32'(bus_a.redirect_cnt), 32'h0);
    chk("b_reset_pc",    bus_b.pc, 32'h0000_1000);

    for (int i = 0; i < 14; i++) begin
      bus_a.stall         = vecs[i].stall;
      bus_a.br_pc4        = vecs[i].br_pc4;
      bus_a.branch_offset = vecs[i].off;
      bus_a.branch_taken  = vecs[i].bt;
      bus_a.jump          = vecs[i].jump;
      bus_a.jump_index    = vecs[i].jidx;
      step();
      chk($sformatf("v%0d_pc", i),    bus_a.pc, vecs[i].pc);
      chk($sformatf("v%0d_pc4", i),   bus_a.pc_plus4, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_flush", i), 32'(bus_a.flush_out), 32'(vecs[i].flush));
      chk($sformatf("v%0d_err", i),   32'(bus_a.addr_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_cnt", i),   32'(bus_a.redirect_cnt), 32'(vecs[i].cnt));
    end
    bus_a.stall = 0; bus_a.branch_taken = 0; bus_a.jump = 0;

    // Overlapping redirect one cycle into a 3-cycle flush; stall must not pause the count.
    drive_b(0, 1, 32'h200, 32'h10);
    step();
    chk("b_br1_pc", bus_b.pc, 32'h0000_0210);
    if (bus_b.flush_out) flush_hi++;
    drive_b(0, 1, 32'h300, 32'h20);
    step();
    chk("b_br2_pc", bus_b.pc, 32'h0000_0320);
    chk("b_br2_flush", 32'(bus_b.flush_out), 32'h1);
    if (bus_b.flush_out) flush_hi++;
    for (int i = 0; i < 2; i++) begin
      drive_b(1, 0, 32'h0, 32'h0);
      step();
      chk($sformatf("b_stall%0d_pc", i), bus_b.pc, 32'h0000_0320);
      chk($sformatf("b_stall%0d_flush", i), 32'(bus_b.flush_out), 32'h1);
      if (bus_b.flush_out) flush_hi++;
    end
    drive_b(0, 0, 32'h0, 32'h0);
    step();
    chk("b_end_flush", 32'(bus_b.flush_out), 32'h0);
    chk("b_end_pc", bus_b.pc, 32'h0000_0324);
    if (bus_b.flush_out) flush_hi++;
    chk("b_flush_total", 32'(flush_hi), 32'd4);
    chk("b_cnt2", 32'(bus_b.redirect_cnt), 32'd2);

    // Three more redirects: the 2-bit counter saturates at 3.
    for (int i = 0; i < 3; i++) begin
      drive_b(0, 1, 32'h400, 32'h0);
      step();
      chk($sformatf("b_sat%0d_cnt", i), 32'(bus_b.redirect_cnt), 32'd3);
      chk($sformatf("b_sat%0d_pc", i), bus_b.pc, 32'h0000_0400);
    end
    drive_b(0, 0, 32'h0, 32'h0);
    chk("b_midflush", 32'(bus_b.flush_out), 32'h1);

    // Asynchronous reset mid-flush, well away from any clock edge.
    #2;
    rst_b_n = 0;
    #1;
    chk("b_async_pc",    bus_b.pc, 32'h0000_1000);
    chk("b_async_flush", 32'(bus_b.flush_out), 32'h0);
    chk("b_async_cnt",   32'(bus_b.redirect_cnt), 32'h0);
    #2;
    rst_b_n = 1;
    step();
    chk("b_post_rst_pc", bus_b.pc, 32'h0000_1004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
